tpsram_rsp: RTL

- Behavioural two-port SRAM responder: the memory end of the sram_re/sram_we/sram_raddr/sram_waddr/sram_wdata/sram_rdata interface that the synchronous FIFO controllers drive.
- Provides 1-cycle registered read latency, read-before-write collision semantics and a hardware clear sequencer.
- Used as the FIFO backing store in simulation and FPGA builds, in place of the foundry macro.

---
 rtl/tpsram_rsp.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tpsram_rsp.sv
// Two-port SRAM responder: 1-cycle registered read, read-before-write, hardware clear.
// Optional stored parity bit and error injection under `TPSRAM_RSP_PARITY_EN.
module tpsram_rsp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_re,
    input  logic [ADDR_W-1:0] sram_raddr,
    output logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_we,
    input  logic [ADDR_W-1:0] sram_waddr,
    input  logic [DATA_W-1:0] sram_wdata,
    input  logic              init_req,
    output logic              init_busy,
`ifdef TPSRAM_RSP_PARITY_EN
    input  logic              perr_inject,
    output logic              rd_perr,
`endif
    output logic              rd_collision
);

    localparam int CNT_W = ADDR_W + 1;
`ifdef TPSRAM_RSP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic               clr_we;
    logic               acc_en;
    logic               rd_in, wr_in;
    logic [MEM_W-1:0]   wr_word;
    logic [MEM_W-1:0]   mem [DEPTH];

    assign acc_en    = (state == IDLE);
    assign init_busy = (state == CLEAR);
    assign rd_in     = ({1'b0, sram_raddr} < CNT_W'(DEPTH));
    assign wr_in     = ({1'b0, sram_waddr} < CNT_W'(DEPTH));

`ifdef TPSRAM_RSP_PARITY_EN
    assign wr_word = {(^sram_wdata) ^ perr_inject, sram_wdata};
`else
    assign wr_word = sram_wdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == CNT_W'(DEPTH - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // No array write on a reset edge, so an interrupted clear leaves the current word intact.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we)
                mem[clr_cnt[ADDR_W-1:0]] <= '0;
            else if (acc_en && sram_we && wr_in)
                mem[sram_waddr] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_rdata   <= '0;
            rd_collision <= 1'b0;
`ifdef TPSRAM_RSP_PARITY_EN
            rd_perr      <= 1'b0;
`endif
        end else begin
            rd_collision <= 1'b0;
            if (acc_en && sram_re) begin
                if (rd_in) begin
                    sram_rdata   <= mem[sram_raddr][DATA_W-1:0];
                    rd_collision <= sram_we && (sram_waddr == sram_raddr);
`ifdef TPSRAM_RSP_PARITY_EN
                    rd_perr      <= ^mem[sram_raddr];
`endif
                end else begin
                    sram_rdata <= '0;
`ifdef TPSRAM_RSP_PARITY_EN
                    rd_perr    <= 1'b0;
`endif
                end
            end
`ifdef TPSRAM_RSP_PARITY_EN
            else if (!acc_en) begin
                rd_perr <= 1'b0;
            end
`endif
        end
    end

endmodule
